// File: rtl/mer_calc_log_pkg.sv
// Shared constants and elaboration-time helpers for the log-domain MER calculator.
// Holds the log2 mantissa LUT generator, the dB scale constant and the saturation limits.
package mer_calc_log_pkg;

  localparam int unsigned MER_K      = 49321;  // round(10*log10(2) * 2^14)
  localparam int unsigned MER_K_FRAC = 14;
  localparam int unsigned MER_K_W    = 17;     // signed width that holds MER_K

  function automatic int unsigned mer_shift(input int unsigned log_frac,
                                            input int unsigned out_frac);
    return log_frac + MER_K_FRAC - out_frac;
  endfunction

  function automatic int sat_max(input int unsigned out_w);
    return int'((longint'(1) <<< (out_w - 1)) - 1);
  endfunction

  function automatic int sat_min(input int unsigned out_w);
    return -sat_max(out_w) - 1;
  endfunction

  // round(2^log_frac * log2(1 + k/2^mant_bits)) by repeated squaring in Q30.
  function automatic int unsigned log2_lut_val(input int unsigned k,
                                               input int unsigned mant_bits,
                                               input int unsigned log_frac);
    logic [63:0] y;
    logic [63:0] bits;
    y    = ((64'(k) << 30) >> mant_bits) + (64'd1 << 30);
    bits = '0;
    for (int unsigned i = 0; i <= log_frac; i++) begin
      y    = (y * y) >> 30;
      bits = bits << 1;
      if (y >= (64'd2 << 30)) begin
        y    = y >> 1;
        bits = bits | 64'd1;
      end
    end
    return 32'((bits + 64'd1) >> 1);
  endfunction

endpackage

// File: rtl/mer_calc_log_log2_approx.sv
// Fixed-point log2 approximation: registered leading-one position and mantissa,
// followed by a combinational mantissa LUT lookup.
module mer_calc_log_log2_approx
  import mer_calc_log_pkg::*;
#(
  parameter int unsigned PWR_W     = 18,
  parameter int unsigned MANT_BITS = 6,
  parameter int unsigned LOG_FRAC  = 8
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset,
  input  logic                                 i_en,
  input  logic [PWR_W-1:0]                     i_x,
  output logic [$clog2(PWR_W)+LOG_FRAC-1:0]    o_log2_c
);

  localparam int unsigned P_W   = $clog2(PWR_W);
  localparam int unsigned LOG_W = P_W + LOG_FRAC;
  localparam int unsigned LUT_N = 2 ** MANT_BITS;

  int unsigned          w_pos;
  logic [MANT_BITS-1:0] w_mant;
  logic [LOG_FRAC:0]    w_lut [LUT_N];
  logic [P_W-1:0]       r_pos;
  logic [MANT_BITS-1:0] r_mant;

  for (genvar g = 0; g < LUT_N; g++) begin : g_lut
    assign w_lut[g] = (LOG_FRAC+1)'(log2_lut_val(g, MANT_BITS, LOG_FRAC));
  end

  // The leading one lands just above the mantissa field and is truncated away.
  always_comb begin
    w_pos = 0;
    for (int unsigned i = 0; i < PWR_W; i++) begin
      if (i_x[i]) w_pos = i;
    end
    if (w_pos >= MANT_BITS) w_mant = MANT_BITS'(i_x >> (w_pos - MANT_BITS));
    else                    w_mant = MANT_BITS'(i_x << (MANT_BITS - w_pos));
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pos  <= '0;
      r_mant <= '0;
    end else if (i_en) begin
      r_pos  <= P_W'(w_pos);
      r_mant <= w_mant;
    end
  end

  assign o_log2_c = {r_pos, LOG_FRAC'(0)} + LOG_W'(w_lut[r_mant]);

endmodule

// File: rtl/mer_calc_log.sv
// MER in dB from mapper/error power via log2 difference, 4-stage pipeline,
// with saturation/error flags and running min-MER / error-count statistics.
module mer_calc_log
  import mer_calc_log_pkg::*;
#(
  parameter int unsigned PWR_W     = 18,
  parameter int unsigned MANT_BITS = 6,
  parameter int unsigned LOG_FRAC  = 8,
  parameter int unsigned OUT_W     = 12,
  parameter int unsigned OUT_FRAC  = 4,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 in_valid,
  input  logic [PWR_W-1:0]     mapper_power,
  input  logic [PWR_W-1:0]     error_power,
  input  logic                 stats_clear,
  output logic                 out_valid,
  output logic [OUT_W-1:0]     mer_db,
  output logic                 mer_err,
  output logic                 mer_sat,
  output logic [OUT_W-1:0]     mer_min,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned LOG_W  = $clog2(PWR_W) + LOG_FRAC;
  localparam int unsigned DIFF_W = LOG_W + 1;
  localparam int unsigned PROD_W = DIFF_W + MER_K_W;
  localparam int unsigned SH     = mer_shift(LOG_FRAC, OUT_FRAC);

  localparam logic signed [PROD_W-1:0] K_P   = PROD_W'(MER_K);
  localparam logic signed [PROD_W-1:0] RND_P = PROD_W'(longint'(1) <<< (SH - 1));
  localparam logic signed [PROD_W-1:0] MAX_P = PROD_W'(sat_max(OUT_W));
  localparam logic signed [PROD_W-1:0] MIN_P = PROD_W'(sat_min(OUT_W));
  localparam logic [OUT_W-1:0]         MIN_RST = OUT_W'(sat_max(OUT_W));

  logic                     r_s1_valid, r_s1_err;
  logic [PWR_W-1:0]         r_s1_m, r_s1_e;
  logic                     r_s2_valid, r_s2_err;
  logic                     r_s3_valid, r_s3_err;
  logic signed [DIFF_W-1:0] r_s3_diff;

  logic [LOG_W-1:0]         w_log_m, w_log_e;
  logic signed [PROD_W-1:0] w_prod, w_rnd;
  logic                     w_hi, w_lo;
  logic [OUT_W-1:0]         w_db;
  logic                     w_sat;

  mer_calc_log_log2_approx #(
    .PWR_W(PWR_W), .MANT_BITS(MANT_BITS), .LOG_FRAC(LOG_FRAC)
  ) u_log_m (
    .i_clk(clk), .i_reset(reset), .i_en(clk_en), .i_x(r_s1_m), .o_log2_c(w_log_m)
  );

  mer_calc_log_log2_approx #(
    .PWR_W(PWR_W), .MANT_BITS(MANT_BITS), .LOG_FRAC(LOG_FRAC)
  ) u_log_e (
    .i_clk(clk), .i_reset(reset), .i_en(clk_en), .i_x(r_s1_e), .o_log2_c(w_log_e)
  );

  // Scale log2 difference to dB, round half up, then clip to the output range.
  always_comb begin
    w_prod = PROD_W'(r_s3_diff) * K_P;
    w_rnd  = (w_prod + RND_P) >>> SH;
    w_hi   = w_rnd > MAX_P;
    w_lo   = w_rnd < MIN_P;
    w_sat  = 1'b0;
    if (r_s3_err) begin
      w_db = '1;
    end else if (w_hi) begin
      w_db  = OUT_W'(MAX_P);
      w_sat = 1'b1;
    end else if (w_lo) begin
      w_db  = OUT_W'(MIN_P);
      w_sat = 1'b1;
    end else begin
      w_db = OUT_W'(w_rnd);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_m     <= '0;
      r_s1_e     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_err   <= 1'b0;
      r_s3_valid <= 1'b0;
      r_s3_err   <= 1'b0;
      r_s3_diff  <= '0;
      out_valid  <= 1'b0;
      mer_db     <= '0;
      mer_err    <= 1'b0;
      mer_sat    <= 1'b0;
      mer_min    <= MIN_RST;
      err_cnt    <= '0;
    end else if (clk_en) begin
      r_s1_valid <= in_valid;
      r_s1_err   <= (mapper_power == '0) || (error_power == '0);
      r_s1_m     <= mapper_power;
      r_s1_e     <= error_power;
      r_s2_valid <= r_s1_valid;
      r_s2_err   <= r_s1_err;
      r_s3_valid <= r_s2_valid;
      r_s3_err   <= r_s2_err;
      r_s3_diff  <= DIFF_W'($signed({1'b0, w_log_m}) - $signed({1'b0, w_log_e}));
      out_valid  <= r_s3_valid;
      if (r_s3_valid) begin
        mer_db  <= w_db;
        mer_err <= r_s3_err;
        mer_sat <= w_sat;
      end
      // Statistics track the result being loaded this cycle; clear takes priority.
      if (stats_clear) begin
        mer_min <= MIN_RST;
        err_cnt <= '0;
      end else if (r_s3_valid) begin
        if (r_s3_err) begin
          if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
        end else if ($signed(w_db) < $signed(mer_min)) begin
          mer_min <= w_db;
        end
      end
    end
  end

endmodule

// File: tb/tb_mer_calc_log.sv
// Bench for mer_calc_log: directed scenarios plus randomized traffic, checked every
// cycle against a real-arithmetic MER model and a 4-enabled-cycle delay line.
module tb_mer_calc_log;

  localparam int PWR_W = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, clk_en, in_valid, stats_clear;
  logic [PWR_W-1:0] mapper_power, error_power;

  logic        out_valid, mer_err, mer_sat;
  logic [11:0] mer_db, mer_min;
  logic [15:0] err_cnt;

  logic        out_valid10, mer_err10, mer_sat10;
  logic [9:0]  mer_db10, mer_min10;
  logic [15:0] err_cnt10;

  mer_calc_log dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .in_valid(in_valid),
    .mapper_power(mapper_power), .error_power(error_power), .stats_clear(stats_clear),
    .out_valid(out_valid), .mer_db(mer_db), .mer_err(mer_err), .mer_sat(mer_sat),
    .mer_min(mer_min), .err_cnt(err_cnt)
  );

  mer_calc_log #(.OUT_W(10)) dut10 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .in_valid(in_valid),
    .mapper_power(mapper_power), .error_power(error_power), .stats_clear(stats_clear),
    .out_valid(out_valid10), .mer_db(mer_db10), .mer_err(mer_err10), .mer_sat(mer_sat10),
    .mer_min(mer_min10), .err_cnt(err_cnt10)
  );

  typedef struct {
    bit          v;
    int unsigned m;
    int unsigned e;
  } smp_t;

  smp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  bit exp_ov, exp_err, exp_sat, exp10_sat, exp10_err;
  int exp_db, exp_min, exp_cnt, exp10_db;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_log2(input int unsigned x);
    int unsigned p = 0;
    int unsigned mant;
    real         r;
    for (int i = 0; i < PWR_W; i++) if (((x >> i) & 1) != 0) p = i;
    mant = (p >= 6) ? ((x >> (p - 6)) & 63) : ((x << (6 - p)) & 63);
    r = 256.0 * $ln(1.0 + real'(mant) / 64.0) / $ln(2.0);
    return int'(p) * 256 + $rtoi($floor(r + 0.5));
  endfunction

  task automatic ref_mer(input int unsigned m, input int unsigned e, input int out_w,
                         output int db, output bit err, output bit sat);
    longint d, qv, hi, lo;
    err = 1'b0;
    sat = 1'b0;
    if (m == 0 || e == 0) begin
      err = 1'b1;
      db  = -1;
      return;
    end
    d  = longint'(ref_log2(m)) - longint'(ref_log2(e));
    qv = (d * 49321 + (longint'(1) << 17)) >>> 18;
    hi = (longint'(1) << (out_w - 1)) - 1;
    lo = -hi - 1;
    if (qv > hi)      begin qv = hi; sat = 1'b1; end
    else if (qv < lo) begin qv = lo; sat = 1'b1; end
    db = int'(qv);
  endtask

  task automatic model_edge();
    smp_t s;
    if (reset) begin
      q.delete();
      repeat (3) q.push_back('{v: 1'b0, m: 0, e: 0});
      exp_ov = 0; exp_db = 0; exp_err = 0; exp_sat = 0;
      exp_min = 2047; exp_cnt = 0; exp10_db = 0; exp10_sat = 0;
    end else if (clk_en) begin
      s.v = in_valid;
      s.m = 32'(mapper_power);
      s.e = 32'(error_power);
      q.push_back(s);
      s = q.pop_front();
      exp_ov = s.v;
      if (s.v) begin
        ref_mer(s.m, s.e, 12, exp_db, exp_err, exp_sat);
        ref_mer(s.m, s.e, 10, exp10_db, exp10_err, exp10_sat);
      end
      if (stats_clear) begin
        exp_min = 2047;
        exp_cnt = 0;
      end else if (s.v) begin
        if (exp_err) begin
          if (exp_cnt < 65535) exp_cnt++;
        end else if (exp_db < exp_min) begin
          exp_min = exp_db;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("out_valid", longint'(out_valid), longint'(exp_ov));
    chk("mer_db", longint'($signed(mer_db)), longint'(exp_db));
    chk("mer_err", longint'(mer_err), longint'(exp_err));
    chk("mer_sat", longint'(mer_sat), longint'(exp_sat));
    chk("mer_min", longint'($signed(mer_min)), longint'(exp_min));
    chk("err_cnt", longint'(err_cnt), longint'(exp_cnt));
    chk("out_valid10", longint'(out_valid10), longint'(exp_ov));
    chk("mer_db10", longint'($signed(mer_db10)), longint'(exp10_db));
    chk("mer_sat10", longint'(mer_sat10), longint'(exp10_sat));
  endtask

  task automatic drive(input bit v, input int unsigned m, input int unsigned e);
    in_valid     = v;
    mapper_power = PWR_W'(m);
    error_power  = PWR_W'(e);
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b1; in_valid = 1'b0; stats_clear = 1'b0;
    mapper_power = '0; error_power = '0;
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_min", longint'($signed(mer_min)), 2047);
    chk("rst_ov", longint'(out_valid), 0);

    // 2048/2 -> 30.125 dB after 4 enabled cycles
    drive(1, 2048, 2); idle(3);
    chk("tp1_ov", longint'(out_valid), 1);
    chk("tp1_db", longint'($signed(mer_db)), 482);
    chk("tp1_min", longint'($signed(mer_min)), 482);

    // back-to-back: 0 dB then -27.0625 dB
    drive(1, 1000, 1000); drive(1, 4, 2048); idle(2);
    chk("tp2_db0", longint'($signed(mer_db)), 0);
    idle(1);
    chk("tp2_db1", longint'($signed(mer_db)), -433);
    chk("tp2_min", longint'($signed(mer_min)), -433);

    // zero powers flag errors
    drive(1, 1000, 0); drive(1, 0, 5); idle(2);
    chk("tp3_err", longint'(mer_err), 1);
    chk("tp3_db", longint'($signed(mer_db)), -1);
    idle(1);
    chk("tp3_cnt", longint'(err_cnt), 2);
    chk("tp3_min", longint'($signed(mer_min)), -433);

    // saturation on the narrow instance only
    drive(1, 2048, 1); idle(3);
    chk("tp4_db10", longint'($signed(mer_db10)), 511);
    chk("tp4_sat10", longint'(mer_sat10), 1);
    chk("tp4_db", longint'($signed(mer_db)), 530);

    // clk_en gap mid-pipeline, then freeze with out_valid high
    drive(1, 2048, 2); idle(1);
    clk_en = 1'b0; idle(3);
    chk("tp5_gap_ov", longint'(out_valid), 0);
    clk_en = 1'b1; idle(2);
    chk("tp5_ov", longint'(out_valid), 1);
    chk("tp5_db", longint'($signed(mer_db)), 482);
    clk_en = 1'b0; idle(2);
    chk("tp5_hold_ov", longint'(out_valid), 1);
    chk("tp5_hold_db", longint'($signed(mer_db)), 482);
    clk_en = 1'b1;

    // reset with samples in flight
    drive(1, 100, 3); drive(1, 5, 7); drive(1, 9, 0);
    reset = 1'b1; idle(1); reset = 1'b0;
    chk("tp6_ov", longint'(out_valid), 0);
    chk("tp6_min", longint'($signed(mer_min)), 2047);
    chk("tp6_cnt", longint'(err_cnt), 0);
    chk("tp6_db", longint'($signed(mer_db)), 0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("tp6_flush_ov", longint'(out_valid), 0);
    end

    // stats_clear coinciding with an error result
    drive(1, 0, 0); idle(3);
    chk("tp7_cnt1", longint'(err_cnt), 1);
    drive(1, 5, 0); idle(2);
    stats_clear = 1'b1; idle(2); stats_clear = 1'b0;
    chk("tp7_cnt0", longint'(err_cnt), 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int unsigned m, e;
      m = ($urandom & 32'h3FFFF) >> $urandom_range(0, 17);
      e = ($urandom & 32'h3FFFF) >> $urandom_range(0, 17);
      if ($urandom_range(0, 15) == 0) m = 0;
      if ($urandom_range(0, 15) == 0) e = 0;
      clk_en      = ($urandom_range(0, 9) < 8);
      stats_clear = ($urandom_range(0, 29) == 0);
      reset       = ($urandom_range(0, 99) == 0);
      drive(1'($urandom_range(0, 3) != 0), m, e);
    end
    reset = 1'b0; stats_clear = 1'b0; clk_en = 1'b1;
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
